// File: rtl/hbridge_deadtime_ctrl.sv
// H-bridge gate controller: PWM + direction in, four gate commands out.
// Programmable deadtime, sequenced direction reversal and a latched fault.
module hbridge_deadtime_ctrl #(
    parameter int unsigned DT_W       = 8,
    parameter int unsigned DT_DEFAULT = 50,
    parameter int unsigned DT_MIN     = 4,
    parameter int unsigned REV_MULT   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            pwm_in,
    input  logic            dir,
    input  logic [DT_W-1:0] dt_cycles,
    input  logic            dt_load,
    input  logic            fault,
    input  logic            fault_clr,
    output logic            H1,
    output logic            L1,
    output logic            H2,
    output logic            L2,
    output logic            in_deadtime,
    output logic            fault_latched,
    output logic            dir_active
);

    localparam int unsigned CNT_W = DT_W + 2;

    typedef enum logic [2:0] {
        StIdle,
        StDriveHi,
        StDriveLo,
        StDead,
        StRev,
        StFault
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dead_init, rev_init;
    logic [DT_W-1:0]  dt_q, dt_clamped;
    logic             pwm_q, dir_q;
    logic             dir_act_d;
    logic             h1_d, l1_d, h2_d, l2_d;

    assign dt_clamped = (dt_cycles < DT_W'(DT_MIN)) ? DT_W'(DT_MIN) : dt_cycles;
    assign dead_init  = CNT_W'(dt_q) - CNT_W'(1);
    assign rev_init   = CNT_W'(REV_MULT) * CNT_W'(dt_q) - CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_act_d = dir_active;
        if (fault) begin
            state_d = StFault;
        end else if (!enable && state_q != StFault) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d   = StDead;
                    cnt_d     = dead_init;
                    dir_act_d = dir_q;
                end
                // A direction change outranks a PWM edge seen in the same cycle.
                StDriveHi, StDriveLo: begin
                    if (dir_q != dir_active) begin
                        state_d = StRev;
                        cnt_d   = rev_init;
                    end else if (pwm_q != (state_q == StDriveHi)) begin
                        state_d = StDead;
                        cnt_d   = dead_init;
                    end
                end
                StDead, StRev: begin
                    if (cnt_q == '0) begin
                        state_d = pwm_q ? StDriveHi : StDriveLo;
                        if (state_q == StRev) begin
                            dir_act_d = dir_q;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StFault: begin
                    if (fault_clr) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        if (state_d == StIdle || state_d == StFault) begin
            dir_act_d = 1'b0;
        end
    end

    // Gate commands are decoded from the next state so the outputs are registered.
    always_comb begin
        h1_d = 1'b0;
        l1_d = 1'b0;
        h2_d = 1'b0;
        l2_d = 1'b0;
        unique case (state_d)
            StDriveHi: begin
                h1_d = !dir_act_d;
                l2_d = !dir_act_d;
                h2_d = dir_act_d;
                l1_d = dir_act_d;
            end
            StDriveLo: begin
                l1_d = 1'b1;
                l2_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            dt_q          <= DT_W'(DT_DEFAULT);
            pwm_q         <= 1'b0;
            dir_q         <= 1'b0;
            dir_active    <= 1'b0;
            H1            <= 1'b0;
            L1            <= 1'b0;
            H2            <= 1'b0;
            L2            <= 1'b0;
            in_deadtime   <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            pwm_q         <= pwm_in;
            dir_q         <= dir;
            if (dt_load) begin
                dt_q <= dt_clamped;
            end
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dir_active    <= dir_act_d;
            H1            <= h1_d;
            L1            <= l1_d;
            H2            <= h2_d;
            L2            <= l2_d;
            in_deadtime   <= (state_d == StDead) || (state_d == StRev);
            fault_latched <= (state_d == StFault);
        end
    end

endmodule

// File: tb/tb_hbridge_deadtime_ctrl.sv
// Directed bench for hbridge_deadtime_ctrl: vector table plus hand-written corner sequences.
module tb_hbridge_deadtime_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       pwm_in;
    logic       dir;
    logic [7:0] dt_cycles;
    logic       dt_load;
    logic       fault;
    logic       fault_clr;
    logic       H1, L1, H2, L2;
    logic       in_deadtime, fault_latched, dir_active;

    int tests = 0;
    int fails = 0;
    int overlap = 0;

    // Expected-output encoding: {H1, L1, H2, L2, in_deadtime, fault_latched, dir_active}
    localparam logic [6:0] LO0   = 7'b0101_000;
    localparam logic [6:0] HI0   = 7'b1001_000;
    localparam logic [6:0] LO1   = 7'b0101_001;
    localparam logic [6:0] HI1   = 7'b0110_001;
    localparam logic [6:0] OFF   = 7'b0000_000;
    localparam logic [6:0] DEAD0 = 7'b0000_100;
    localparam logic [6:0] FLT   = 7'b0000_010;

    typedef struct {
        logic       ld;
        logic [7:0] dt;
        logic       pwm;
        logic       dir;
        int         off;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[10];

    hbridge_deadtime_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .pwm_in        (pwm_in),
        .dir           (dir),
        .dt_cycles     (dt_cycles),
        .dt_load       (dt_load),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .H1            (H1),
        .L1            (L1),
        .H2            (H2),
        .L2            (L2),
        .in_deadtime   (in_deadtime),
        .fault_latched (fault_latched),
        .dir_active    (dir_active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((H1 && L1) || (H2 && L2)) overlap++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input logic [6:0] exp, input string name);
        logic [6:0] act;
        act = {H1, L1, H2, L2, in_deadtime, fault_latched, dir_active};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // n cycles with every gate off and in_deadtime set, then one cycle showing exp.
    task automatic expect_dead(input int n, input logic [6:0] exp, input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if ({H1, L1, H2, L2, in_deadtime} !== 5'b00001) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s_offwindow: got %0d bad cycles expected 0", name, bad);
        end
        tick();
        check(exp, name);
    endtask

    task automatic seq(input logic p, input logic d, input int n, input logic [6:0] exp,
                       input string name);
        pwm_in = p;
        dir    = d;
        tick();
        expect_dead(n, exp, name);
    endtask

    task automatic load_dt(input logic [7:0] v);
        dt_cycles = v;
        dt_load   = 1'b1;
        tick();
        dt_load   = 1'b0;
    endtask

    initial begin
        int h1_seen;
        rst       = 1'b1;
        enable    = 1'b0;
        pwm_in    = 1'b0;
        dir       = 1'b0;
        dt_cycles = 8'd0;
        dt_load   = 1'b0;
        fault     = 1'b0;
        fault_clr = 1'b0;

        tbl[0] = '{1'b0, 8'd0,   1'b1, 1'b0, 50,  HI0, "rise_dt50"};
        tbl[1] = '{1'b1, 8'd2,   1'b0, 1'b0, 4,   LO0, "fall_dt2_clamped"};
        tbl[2] = '{1'b1, 8'd200, 1'b1, 1'b0, 200, HI0, "rise_dt200"};
        tbl[3] = '{1'b1, 8'd50,  1'b1, 1'b1, 100, HI1, "rev_from_hi"};
        tbl[4] = '{1'b0, 8'd0,   1'b0, 1'b1, 50,  LO1, "fall_dir1"};
        tbl[5] = '{1'b0, 8'd0,   1'b0, 1'b0, 100, LO0, "rev_from_lo"};
        tbl[6] = '{1'b1, 8'd5,   1'b1, 1'b0, 5,   HI0, "rise_dt5"};
        tbl[7] = '{1'b1, 8'd0,   1'b0, 1'b0, 4,   LO0, "fall_dt0_clamped"};
        tbl[8] = '{1'b1, 8'd50,  1'b1, 1'b0, 50,  HI0, "rise_dt50_again"};
        tbl[9] = '{1'b0, 8'd0,   1'b0, 1'b0, 50,  LO0, "fall_dt50"};

        repeat (3) tick();
        check(OFF, "reset");
        rst    = 1'b0;
        enable = 1'b1;
        expect_dead(50, LO0, "startup");

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].ld) load_dt(tbl[i].dt);
            seq(tbl[i].pwm, tbl[i].dir, tbl[i].off, tbl[i].exp, tbl[i].name);
        end

        // Short pulse is absorbed by one deadtime interval.
        h1_seen = 0;
        pwm_in  = 1'b1;
        for (int i = 1; i <= 51; i++) begin
            tick();
            if (H1) h1_seen++;
            if (i == 10) pwm_in = 1'b0;
            if (i >= 2 && {H1, L1, H2, L2, in_deadtime} !== 5'b00001) h1_seen += 1000;
        end
        tick();
        check(LO0, "short_pulse_back_lo");
        tests++;
        if (h1_seen != 0) begin
            fails++;
            $display("FAIL short_pulse_window: got %0d bad cycles expected 0", h1_seen);
        end

        // Load coinciding with DEAD entry: running interval keeps the old value.
        pwm_in = 1'b1;
        tick();
        dt_cycles = 8'd8;
        dt_load   = 1'b1;
        tick();
        dt_load   = 1'b0;
        check(DEAD0, "load_at_dead_entry");
        expect_dead(49, HI0, "old_dt_kept");
        seq(1'b0, 1'b0, 8, LO0, "new_dt_used");

        seq(1'b1, 1'b1, 16, HI1, "pwm_and_dir_rev_wins");
        seq(1'b0, 1'b0, 16, LO0, "pwm_and_dir_rev_back");

        // Fault mid-DEAD.
        pwm_in = 1'b1;
        repeat (4) tick();
        fault = 1'b1;
        tick();
        check(FLT, "fault_entry");
        fault_clr = 1'b1;
        tick();
        check(FLT, "fault_clr_ignored");
        fault_clr = 1'b0;
        fault     = 1'b0;
        tick();
        check(FLT, "fault_held");
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check(OFF, "fault_clr_idle");
        expect_dead(8, HI0, "restart_after_fault");

        enable = 1'b0;
        tick();
        check(OFF, "disable_idle");
        enable = 1'b1;
        expect_dead(8, HI0, "reenable");

        tests++;
        if (overlap != 0) begin
            fails++;
            $display("FAIL shoot_through: got %0d cycles expected 0", overlap);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
